core_slot_ctrl: RTL

Core-side control endpoint that terminates the scheduler's control channel for one core. It decodes scheduler-to-core commands: the reset command, and type-0 descriptors that carry loopback traffic. It also generates core-to-scheduler messages: type-3 slot-count load at start-up, type-0 slot release, and type-1 loopback descriptor. It tracks slot occupancy to catch allocation and release errors. One instance sits between each core and its port on the control interconnect.

---
 rtl/core_slot_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_slot_ctrl.sv
// core_slot_ctrl: core-side endpoint of the scheduler control channel.
// It decodes scheduler commands (the reset command and type-0 descriptors)
// and sends core messages (type-3 slot count, type-0 slot release, type-1
// loopback). It also tracks which slots are busy, to flag allocation and
// release errors.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holds valid and its data stable until that edge.
// A consumer may drive ready from its inputs within the same cycle.
module core_slot_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int SLOT_COUNT = 8,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
  parameter int LEN_WIDTH  = 16,
  parameter int RST_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ctrl_s_axis_tdata,
  input  logic                  ctrl_s_axis_tvalid,
  output logic                  ctrl_s_axis_tready,
  input  logic                  ctrl_s_axis_tlast,
  output logic [DATA_WIDTH-1:0] ctrl_m_axis_tdata,
  output logic                  ctrl_m_axis_tvalid,
  input  logic                  ctrl_m_axis_tready,
  output logic                  ctrl_m_axis_tlast,
  input  logic                  slot_free_valid,
  output logic                  slot_free_ready,
  input  logic [SLOT_WIDTH-1:0] slot_free_slot,
  input  logic [LEN_WIDTH-1:0]  slot_free_len,
  input  logic                  lb_valid,
  output logic                  lb_ready,
  input  logic [DATA_WIDTH-5:0] lb_data,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [DATA_WIDTH-1:0] desc_data,
  input  logic                  pkt_start_valid,
  input  logic [SLOT_WIDTH-1:0] pkt_start_slot,
  output logic                  core_reset,
  output logic [SLOT_WIDTH-1:0] slots_busy,
  output logic                  err_double_free,
  output logic                  err_double_alloc,
  output logic                  err_slot_range,
  output logic [1:0]            dbg_state
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  // The reset command is all ones except bit 0.
  localparam logic [DATA_WIDTH-1:0] RST_CMD = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_WAIT_CMD = 2'd0,
    ST_HOLD     = 2'd1,
    ST_LOAD     = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [HOLD_W-1:0]       cnt_q, cnt_d;
  logic [SLOT_COUNT-1:0]   busy_q, busy_d;
  logic [SLOT_WIDTH-1:0]   pop_q, pop_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    desc_valid_q, desc_valid_d;
  logic [DATA_WIDTH-1:0]   desc_data_q, desc_data_d;
  logic                    err_free_q, err_free_d;
  logic                    err_alloc_q, err_alloc_d;
  logic                    err_range_q, err_range_d;

  logic                    is_rst_word, is_type0, rst_cmd, desc_take;
  logic                    can_load, load3, free_hs, lb_hs, free_ok, alloc_v;
  logic [SLOT_COUNT-1:0]   free_mask, alloc_mask, clr_mask, set_mask;
  logic                    free_busy, alloc_busy;
  logic [DATA_WIDTH-1:0]   msg3, msg0, msg1;

  // Command decode and the input-side ready.
  always_comb begin
    is_rst_word        = (ctrl_s_axis_tdata == RST_CMD);
    is_type0           = (ctrl_s_axis_tdata[DATA_WIDTH-1 -: 4] == 4'd0) && !is_rst_word;
    ctrl_s_axis_tready = is_type0 ? (!desc_valid_q || desc_ready) : 1'b1;
    rst_cmd            = ctrl_s_axis_tvalid && is_rst_word;
    desc_take          = ctrl_s_axis_tvalid && ctrl_s_axis_tready && is_type0;
  end

  // Core-side readies: only in RUN, only when the output register can load.
  // A slot free wins over a loopback.
  always_comb begin
    can_load        = !m_valid_q || ctrl_m_axis_tready;
    slot_free_ready = (state_q == ST_RUN) && can_load;
    lb_ready        = (state_q == ST_RUN) && can_load && !slot_free_valid;
    free_hs         = slot_free_valid && slot_free_ready;
    lb_hs           = lb_valid && lb_ready;
    load3           = (state_q == ST_LOAD) && can_load && !rst_cmd;
    core_reset      = (state_q != ST_RUN);
    alloc_v         = pkt_start_valid && !core_reset;
  end

  // Slot bookkeeping. An out-of-range slot number gives an empty one-hot
  // mask. The free is checked against the bitmap as it stood before this
  // cycle. The alloc is checked after the free, so an alloc and a free of
  // the same slot in one cycle leave the bit set and flag no error.
  always_comb begin
    free_mask  = '0;
    alloc_mask = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      free_mask[i]  = (slot_free_slot == SLOT_WIDTH'(i + 1));
      alloc_mask[i] = (pkt_start_slot == SLOT_WIDTH'(i + 1));
    end
    free_busy   = |(free_mask & busy_q);
    free_ok     = free_hs && free_busy;
    clr_mask    = free_ok ? free_mask : '0;
    alloc_busy  = |(alloc_mask & busy_q & ~clr_mask);
    set_mask    = alloc_v ? alloc_mask : '0;
    busy_d      = rst_cmd ? '0 : ((busy_q & ~clr_mask) | set_mask);
    err_range_d = err_range_q || (free_hs && !(|free_mask))
                              || (alloc_v && !(|alloc_mask));
    err_free_d  = err_free_q  || (free_hs && (|free_mask) && !free_busy);
    err_alloc_d = err_alloc_q || (alloc_v && alloc_busy);
    pop_d       = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      pop_d = pop_d + SLOT_WIDTH'(busy_q[i]);
    end
  end

  // Outgoing message formats, and the one-deep output register.
  // Load priority is type-3, then slot free, then loopback.
  always_comb begin
    msg3 = '0;
    msg3[DATA_WIDTH-1 -: 4]     = 4'd3;
    msg3[SLOT_WIDTH-1:0]        = SLOT_WIDTH'(SLOT_COUNT);
    msg0 = '0;
    msg0[LEN_WIDTH +: SLOT_WIDTH] = slot_free_slot;
    msg0[LEN_WIDTH-1:0]           = slot_free_len;
    msg1 = {4'd1, lb_data};
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load3) begin
      m_valid_d = 1'b1;
      m_data_d  = msg3;
    end else if (free_ok) begin
      m_valid_d = 1'b1;
      m_data_d  = msg0;
    end else if (lb_hs) begin
      m_valid_d = 1'b1;
      m_data_d  = msg1;
    end else if (ctrl_m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // One-entry descriptor register. A reset command discards its contents.
  always_comb begin
    desc_valid_d = desc_valid_q;
    desc_data_d  = desc_data_q;
    if (rst_cmd) begin
      desc_valid_d = 1'b0;
    end else if (desc_take) begin
      desc_valid_d = 1'b1;
      desc_data_d  = ctrl_s_axis_tdata;
    end else if (desc_ready) begin
      desc_valid_d = 1'b0;
    end
  end

  // FSM next state. A reset command restarts the hold from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_CMD: state_d = ST_WAIT_CMD;
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: if (load3) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WAIT_CMD;
    endcase
    if (rst_cmd) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAIT_CMD;
      cnt_q        <= '0;
      busy_q       <= '0;
      pop_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_data_q  <= '0;
      err_free_q   <= 1'b0;
      err_alloc_q  <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      pop_q        <= pop_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      desc_valid_q <= desc_valid_d;
      desc_data_q  <= desc_data_d;
      err_free_q   <= err_free_d;
      err_alloc_q  <= err_alloc_d;
      err_range_q  <= err_range_d;
    end
  end

  // Output wiring. Each message is a single word, so tlast equals tvalid.
  // The command tlast is not needed for single-word commands.
  always_comb begin
    ctrl_m_axis_tdata  = m_data_q;
    ctrl_m_axis_tvalid = m_valid_q;
    ctrl_m_axis_tlast  = m_valid_q;
    desc_valid         = desc_valid_q;
    desc_data          = desc_data_q;
    slots_busy         = pop_q;
    err_double_free    = err_free_q;
    err_double_alloc   = err_alloc_q;
    err_slot_range     = err_range_q;
    dbg_state          = state_q;
  end

  logic unused_tlast;
  assign unused_tlast = ctrl_s_axis_tlast;

endmodule
